// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared definitions for the multi-byte add sequencer: state encoding,
// default byte width, counter sizing and the end-of-packet flag bundle.
package multibyte_add_sequencer_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [0:0] ST_FIRST = 1'b0;
    localparam logic [0:0] ST_MID   = 1'b1;

    // Counter only has to reach MAX_BYTES-1 before the packet is forced closed.
    function automatic int cnt_width(input int max_bytes);
        return (max_bytes < 2) ? 1 : $clog2(max_bytes);
    endfunction

    typedef struct packed {
        logic last;
        logic cout;
        logic ovf;
        logic trunc;
    } end_flags_t;

endpackage

// File: rtl/multibyte_add_sequencer_adder.sv
// Combinational WIDTH-bit ripple-carry adder: {o_cout, o_sum} = i_a + i_b + i_cin.
module byte_adder8 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_sum[gi]     = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) | (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_carry[WIDTH];

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Streams LSB-first operand bytes through one byte adder, chaining the carry
// within a packet and presenting each sum byte on a single valid/ready register.
import multibyte_add_sequencer_pkg::*;

module multibyte_add_sequencer #(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_byte,
    input  logic [WIDTH-1:0] b_byte,
    input  logic             in_last,
    input  logic             cin_init,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_byte,
    output logic             out_last,
    output logic             cout_final,
    output logic             ovf,
    output logic             trunc
);

    localparam int             CW       = cnt_width(MAX_BYTES);
    localparam logic [CW-1:0]  LAST_IDX = CW'(MAX_BYTES - 1);

    logic [0:0]       r_state;
    logic [CW-1:0]    r_byte_cnt;
    logic             r_carry;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    end_flags_t       r_flags;

    logic             w_accept;
    logic             w_emit;
    logic             w_cin;
    logic             w_end;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // Ready only looks at the output register, so in_valid never reaches out_valid combinationally.
    assign in_ready = !r_out_valid || out_ready || rst;
    assign w_accept = in_valid && in_ready;
    assign w_emit   = r_out_valid && out_ready;

    assign w_cin = (r_state == ST_FIRST) ? cin_init : r_carry;
    assign w_end = in_last || (r_byte_cnt == LAST_IDX);
    assign w_ovf = (a_byte[WIDTH-1] == b_byte[WIDTH-1]) && (w_sum[WIDTH-1] != a_byte[WIDTH-1]);

    byte_adder8 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (a_byte),
        .i_b    (b_byte),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FIRST;
            r_byte_cnt  <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_flags     <= '0;
        end else if (w_accept) begin
            r_sum       <= w_sum;
            r_out_valid <= 1'b1;
            r_carry     <= w_cout;
            if (w_end) begin
                r_flags    <= '{last: 1'b1, cout: w_cout, ovf: w_ovf, trunc: !in_last};
                r_state    <= ST_FIRST;
                r_byte_cnt <= '0;
            end else begin
                r_flags    <= '0;
                r_state    <= ST_MID;
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end else if (w_emit) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign sum_byte   = r_sum;
    assign out_last   = r_flags.last;
    assign cout_final = r_flags.cout;
    assign ovf        = r_flags.ovf;
    assign trunc      = r_flags.trunc;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer: a driver pushes expected results
// into a queue on each accept, and a monitor pops and compares on each emit.
module tb_multibyte_add_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_byte = '0;
    logic [7:0] b_byte = '0;
    logic       in_last = 1'b0;
    logic       cin_init = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum_byte;
    logic       out_last;
    logic       cout_final;
    logic       ovf;
    logic       trunc;

    multibyte_add_sequencer #(
        .WIDTH     (8),
        .MAX_BYTES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_byte     (a_byte),
        .b_byte     (b_byte),
        .in_last    (in_last),
        .cin_init   (cin_init),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum_byte   (sum_byte),
        .out_last   (out_last),
        .cout_final (cout_final),
        .ovf        (ovf),
        .trunc      (trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       ovf;
        logic       trunc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   stalls   = 0;
    bit   burst    = 1'b0;
    int   prev_pop = -1;
    int   n_out    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] s, input logic l, input logic c,
                                input logic o, input logic t);
        exp_t e;
        e.sum = s; e.last = l; e.cout = c; e.ovf = o; e.trunc = t;
        return e;
    endfunction

    // Monitor: one line per emitted result
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got sum=0x%02h with no result expected", sum_byte);
            end else begin
                e = sb.pop_front();
                $display("out #%0d: sum=0x%02h last=%0b cout=%0b ovf=%0b trunc=%0b (exp sum=0x%02h last=%0b)",
                         n_out, sum_byte, out_last, cout_final, ovf, trunc, e.sum, e.last);
                check("sum_byte", 32'(sum_byte), 32'(e.sum));
                check("out_last", 32'(out_last), 32'(e.last));
                if (e.last) begin
                    check("cout_final", 32'(cout_final), 32'(e.cout));
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("trunc", 32'(trunc), 32'(e.trunc));
                end
                if (burst) begin
                    if (prev_pop >= 0) check("no_bubble_gap", 32'(cyc - prev_pop), 32'd1);
                    prev_pop = cyc;
                end
            end
        end
    end

    // Present one byte pair and hold it until accepted; record the expected result.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last,
                        input logic cin, input exp_t e);
        int n;
        a_byte = a; b_byte = b; in_last = last; cin_init = cin; in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            n++;
            if (n > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] full;
        logic        rovf;

        // Reset state
        @(negedge clk);
        check("in_ready_during_reset", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum_byte", 32'(sum_byte), 32'd0);
        check("reset_flags", 32'({out_last, cout_final, ovf, trunc}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-byte packet with signed overflow
        send(8'h7F, 8'h01, 1'b1, 1'b0, mk(8'h80, 1'b1, 1'b0, 1'b1, 1'b0));
        drain();

        // Two-byte packet; cin_init on the second byte must be ignored
        send(8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        send(8'h00, 8'h00, 1'b1, 1'b1, mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0));
        drain();

        // Backpressure mid-packet, carry must survive
        send(8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        out_ready = 1'b0;
        a_byte = 8'h80; b_byte = 8'h80; in_last = 1'b1; cin_init = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_out", 32'({sum_byte, out_last, cout_final, ovf, trunc}), 32'({8'h00, 4'b0000}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'h80, 8'h80, 1'b1, 1'b0, mk(8'h01, 1'b1, 1'b1, 1'b1, 1'b0));
        drain();

        // Truncation at MAX_BYTES, then a fresh packet that uses cin_init
        send(8'h01, 8'h01, 1'b0, 1'b0, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
        send(8'h01, 8'h01, 1'b0, 1'b1, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
        send(8'h01, 8'h01, 1'b0, 1'b1, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
        send(8'h01, 8'h01, 1'b0, 1'b1, mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b1));
        send(8'h01, 8'h01, 1'b1, 1'b1, mk(8'h03, 1'b1, 1'b0, 1'b0, 1'b0));
        drain();

        // Reset mid-packet discards the held output and the carry
        send(8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("after_reset_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(8'h00, 8'h00, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        drain();

        // Full throughput: 8 back-to-back two-byte packets against a 16-bit model
        stalls   = 0;
        prev_pop = -1;
        burst    = 1'b1;
        for (int p = 0; p < 8; p++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            rovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
            send(ra[7:0], rb[7:0], 1'b0, rc, mk(full[7:0], 1'b0, 1'b0, 1'b0, 1'b0));
            send(ra[15:8], rb[15:8], 1'b1, 1'b0, mk(full[15:8], 1'b1, full[16], rovf, 1'b0));
        end
        drain();
        burst = 1'b0;
        check("burst_input_stalls", 32'(stalls), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
